// File: rtl/au_sum_eq_det_pkg.sv
// Shared types and sizing helpers for the sum-equality detector family.
package au_sum_eq_det_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_ONES = 2'd1,
        MODE_EQK  = 2'd2,
        MODE_NEK  = 2'd3
    } mode_e;

    // Number of AND segments needed to cover w bits in groups of s.
    function automatic int unsigned nseg_f(input int unsigned w, input int unsigned s);
        return (w + s - 1) / s;
    endfunction

endpackage

// File: rtl/au_sum_eq_bitmatch.sv
// Per-bit match vector: all ones exactly when (a + b + ci) mod 2^WIDTH equals t.
module au_sum_eq_bitmatch #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] m
);

    logic [WIDTH-1:0] w_rc;

    // Carry each bit would need to receive if every lower sum bit already matches t.
    always_comb begin
        w_rc    = '0;
        w_rc[0] = ci;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            w_rc[i] = (a[i-1] & b[i-1]) | ((a[i-1] | b[i-1]) & ~t[i-1]);
        end
    end

    assign m = ~(a ^ b ^ t ^ w_rc);

endmodule

// File: rtl/au_sum_eq_det_pipe.sv
// Three-stage, flow-controlled detector flagging (a + b + ci) == target.
// Optional saturating hit counter built when AU_SUM_EQ_DET_CNT_EN is defined.
module au_sum_eq_det_pipe
    import au_sum_eq_det_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic [WIDTH-1:0] k,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             z,
    output logic [CNT_W-1:0] hit_cnt,
    input  logic             cnt_clr
);

    localparam int unsigned NSEG  = nseg_f(WIDTH, SEG_W);
    localparam int unsigned PAD_W = NSEG * SEG_W;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_m;
    logic [PAD_W-1:0] w_m_pad;
    logic [NSEG-1:0]  w_seg;
    logic             w_adv;

    logic             r_v1;
    logic [WIDTH-1:0] r_m;
    mode_e            r_mode1;
    logic             r_v2;
    logic [NSEG-1:0]  r_seg;
    mode_e            r_mode2;
    logic             r_v3;
    logic             r_z;

    always_comb begin
        unique case (mode_e'(mode))
            MODE_ZERO: w_t = '0;
            MODE_ONES: w_t = '1;
            default:   w_t = k;
        endcase
    end

    au_sum_eq_bitmatch #(
        .WIDTH (WIDTH)
    ) u_bitmatch (
        .a  (a),
        .b  (b),
        .ci (ci),
        .t  (w_t),
        .m  (w_m)
    );

    // Pad the tail of the last segment with ones so only real bits decide it.
    always_comb begin
        w_m_pad            = '1;
        w_m_pad[WIDTH-1:0] = r_m;
        w_seg              = '0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            w_seg[s] = &w_m_pad[s*SEG_W +: SEG_W];
        end
    end

    assign w_adv    = ~r_v3 | out_ready;
    assign in_ready = w_adv;

    // Whole pipe moves in lockstep; data lanes only load behind a valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_m     <= '0;
            r_mode1 <= MODE_ZERO;
            r_v2    <= 1'b0;
            r_seg   <= '0;
            r_mode2 <= MODE_ZERO;
            r_v3    <= 1'b0;
            r_z     <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_m     <= w_m;
                r_mode1 <= mode_e'(mode);
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_seg   <= w_seg;
                r_mode2 <= r_mode1;
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_z <= (&r_seg) ^ (r_mode2 == MODE_NEK);
            end
        end
    end

    assign out_valid = r_v3;
    assign z         = r_z;

`ifdef AU_SUM_EQ_DET_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Clear wins over a coincident hit; count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_v3 && out_ready && r_z && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign hit_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign hit_cnt          = '0;
`endif

endmodule

// File: tb/tb_au_sum_eq_det_pipe.sv
// Scoreboard bench: a WIDTH=8 instance for directed/sweep/counter steps, a WIDTH=37 instance for random beats.
module tb_au_sum_eq_det_pipe;

`ifdef AU_SUM_EQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic        z;
        int unsigned cyc;
        bit          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, ci, out_valid, out_ready, z, cnt_clr;
    logic [7:0]  a, b, k;
    logic [1:0]  mode;
    logic [1:0]  hit_cnt;

    logic        x_in_valid, x_in_ready, x_ci, x_out_valid, x_out_ready, x_z, x_cnt_clr;
    logic [36:0] x_a, x_b, x_k;
    logic [1:0]  x_mode;
    logic [15:0] x_hit_cnt;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          lat_chk = 1'b1;
    exp_t        sb8[$];
    exp_t        sb37[$];

    au_sum_eq_det_pipe #(.WIDTH(8), .SEG_W(3), .CNT_W(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .k(k), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .z(z),
        .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
    );

    au_sum_eq_det_pipe #(.WIDTH(37), .SEG_W(8), .CNT_W(16)) u_dut37 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .ci(x_ci), .k(x_k), .mode(x_mode),
        .out_valid(x_out_valid), .out_ready(x_out_ready), .z(x_z),
        .hit_cnt(x_hit_cnt), .cnt_clr(x_cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref8(input logic [7:0] ra, input logic [7:0] rb, input logic rci,
                                  input logic [7:0] rk, input logic [1:0] rm);
        logic [7:0] s;
        logic [7:0] t;
        s = ra + rb + 8'(rci);
        t = (rm == 2'd0) ? 8'h00 : (rm == 2'd1) ? 8'hFF : rk;
        return (s == t) ^ (rm == 2'd3);
    endfunction

    function automatic logic ref37(input logic [36:0] ra, input logic [36:0] rb, input logic rci,
                                   input logic [36:0] rk, input logic [1:0] rm);
        logic [36:0] s;
        logic [36:0] t;
        s = ra + rb + 37'(rci);
        t = (rm == 2'd0) ? '0 : (rm == 2'd1) ? '1 : rk;
        return (s == t) ^ (rm == 2'd3);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Deliveries are compared before new acceptances are recorded on the same edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            chk("sb8_nonempty", 64'(sb8.size() > 0), 64'd1);
            if (sb8.size() > 0) begin
                e = sb8.pop_front();
                chk("z8", 64'(z), 64'(e.z));
                if (e.lat) chk("lat8", 64'(cyc - e.cyc), 64'd3);
            end
        end
        if (rst_n && x_out_valid && x_out_ready) begin
            chk("sb37_nonempty", 64'(sb37.size() > 0), 64'd1);
            if (sb37.size() > 0) begin
                e = sb37.pop_front();
                chk("z37", 64'(x_z), 64'(e.z));
                if (e.lat) chk("lat37", 64'(cyc - e.cyc), 64'd3);
            end
        end
        if (rst_n && in_valid && in_ready)
            sb8.push_back('{ref8(a, b, ci, k, mode), cyc, lat_chk});
        if (rst_n && x_in_valid && x_in_ready)
            sb37.push_back('{ref37(x_a, x_b, x_ci, x_k, x_mode), cyc, lat_chk});
    end

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                         input logic [7:0] tk, input logic [1:0] tm);
        bit acc = 1'b0;
        in_valid = 1'b1; a = ta; b = tb; ci = tci; k = tk; mode = tm;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1 acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send8_accepted", 64'(acc), 64'd1);
    endtask

    task automatic send37(input logic [36:0] ta, input logic [36:0] tb, input logic tci,
                          input logic [36:0] tk, input logic [1:0] tm);
        bit acc = 1'b0;
        x_in_valid = 1'b1; x_a = ta; x_b = tb; x_ci = tci; x_k = tk; x_mode = tm;
        for (int n = 0; n < 200 && !acc; n++) begin
            #1 acc = x_in_ready;
            @(posedge clk); #1;
        end
        x_in_valid = 1'b0;
        chk("send37_accepted", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb8.size() == 0 && sb37.size() == 0 && !out_valid && !x_out_valid) break;
            @(posedge clk); #1;
        end
        chk("drain_sb8_empty", 64'(sb8.size()), 64'd0);
        chk("drain_sb37_empty", 64'(sb37.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  kk, tt;
        logic        cc;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; k = '0; mode = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;
        x_in_valid = 1'b0; x_a = '0; x_b = '0; x_ci = 1'b0; x_k = '0; x_mode = '0;
        x_out_ready = 1'b1; x_cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_z", 64'(z), 64'd0);
        chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_x_out_valid", 64'(x_out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back directed beats in every mode.
        send8(8'h0F, 8'hF1, 1'b0, 8'h00, 2'd0);
        send8(8'hFF, 8'h00, 1'b1, 8'h00, 2'd0);
        send8(8'h01, 8'h01, 1'b0, 8'h00, 2'd0);
        send8(8'h80, 8'h7F, 1'b0, 8'h00, 2'd1);
        send8(8'h80, 8'h7F, 1'b1, 8'h00, 2'd1);
        send8(8'h50, 8'h0A, 1'b0, 8'h5A, 2'd2);
        send8(8'h50, 8'h0A, 1'b0, 8'h5A, 2'd3);
        send8(8'h50, 8'h0A, 1'b1, 8'h5A, 2'd2);
        send8(8'h50, 8'h0A, 1'b1, 8'h5A, 2'd3);
        drain();

        // Backpressure: five beats offered while the consumer stalls for six cycles.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send8(8'h0F, 8'hF1, 1'b0, 8'h00, 2'd0);
                send8(8'h01, 8'h01, 1'b0, 8'h00, 2'd0);
                send8(8'hFF, 8'h00, 1'b1, 8'h00, 2'd0);
                send8(8'h10, 8'h10, 1'b0, 8'h00, 2'd0);
                send8(8'h00, 8'h00, 1'b0, 8'h00, 2'd0);
            end
            begin
                repeat (6) begin
                    @(posedge clk); #1;
                    if (out_valid) chk("stall_z_hold", 64'(z), 64'd1);
                end
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_accepted", 64'(sb8.size()), 64'd3);
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Sweep around the hit point in every mode, alongside random wide beats.
        fork
            begin
                for (int md = 0; md < 4; md++) begin
                    kk = 8'($urandom);
                    for (int ai = 0; ai < 256; ai++) begin
                        for (int j = 0; j < 8; j++) begin
                            cc = 1'($urandom_range(0, 1));
                            tt = (md == 0) ? 8'h00 : (md == 1) ? 8'hFF : kk;
                            send8(8'(ai), 8'(tt - 8'(ai) - 8'(cc) + 8'(j) - 8'd4), cc, kk, 2'(md));
                        end
                    end
                end
            end
            begin
                logic [36:0] ra, rb, rk, rt;
                logic        rc;
                logic [1:0]  rm;
                for (int n = 0; n < 10000; n++) begin
                    ra = 37'({$urandom, $urandom});
                    rb = 37'({$urandom, $urandom});
                    rk = 37'({$urandom, $urandom});
                    rc = 1'($urandom_range(0, 1));
                    rm = 2'($urandom_range(0, 3));
                    rt = (rm == 2'd0) ? '0 : (rm == 2'd1) ? '1 : rk;
                    if ($urandom_range(0, 1) == 1) rb = rt - ra - 37'(rc);
                    send37(ra, rb, rc, rk, rm);
                end
            end
        join
        drain();

        // Hit counter: saturation, clear priority, then a fresh increment.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_cleared", 64'(hit_cnt), 64'd0);
        repeat (5) send8(8'h00, 8'h00, 1'b0, 8'h00, 2'd0);
        drain();
        chk("cnt_saturated", 64'(hit_cnt), CNT_ON ? 64'd3 : 64'd0);
        send8(8'h00, 8'h00, 1'b0, 8'h00, 2'd0);
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("clr_hit_out_valid", 64'(out_valid), 64'd1);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", 64'(hit_cnt), 64'd0);
        send8(8'h00, 8'h00, 1'b0, 8'h00, 2'd0);
        drain();
        chk("cnt_increment", 64'(hit_cnt), CNT_ON ? 64'd1 : 64'd0);

        // Reset with two beats in flight must discard them.
        send8(8'h0F, 8'hF1, 1'b0, 8'h00, 2'd0);
        send8(8'hFF, 8'h00, 1'b1, 8'h00, 2'd0);
        rst_n = 1'b0;
        sb8.delete();
        #2;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_hit_cnt", 64'(hit_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        chk("postrst_sb8_empty", 64'(sb8.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
